// File: rtl/arm_position_scanner.sv
// Scans an inclusive, wrapping address range of the position memory and reports the entry
// with the largest or smallest key. Define ARM_POSITION_SCANNER_ABORT_EN to add the abort input.
module arm_position_scanner #(
    parameter  int AXIS_WIDTH    = 10,
    parameter  int NUM_AXES      = 3,
    parameter  int ADDRESS_WIDTH = 8,
    localparam int DATA_WIDTH    = AXIS_WIDTH * NUM_AXES,
    localparam int DEPTH         = 2 ** ADDRESS_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [ADDRESS_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    input  logic                     start,
`ifdef ARM_POSITION_SCANNER_ABORT_EN
    input  logic                     abort,
`endif
    input  logic [ADDRESS_WIDTH-1:0] start_addr,
    input  logic [ADDRESS_WIDTH-1:0] end_addr,
    input  logic                     mode,
    input  logic [1:0]               axis_sel,
    output logic                     busy,
    output logic                     done,
    output logic                     valid,
    output logic [DATA_WIDTH-1:0]    result_value,
    output logic [ADDRESS_WIDTH-1:0] result_addr
);

    typedef enum logic [1:0] {IDLE, SCAN, FLUSH, DONE} state_t;

    state_t                   state, next_state;
    logic                     abort_req;
    logic                     accept;
    logic [DATA_WIDTH-1:0]    mem [DEPTH];

    logic [ADDRESS_WIDTH-1:0] rd_ptr;
    logic [ADDRESS_WIDTH-1:0] remaining;
    logic                     mode_q;
    logic [1:0]               sel_q;
    logic                     first_pending;

    logic [DATA_WIDTH-1:0]    rd_data;
    logic                     rd_vld;
    logic                     rd_first;
    logic                     rd_last;
    logic [ADDRESS_WIDTH-1:0] rd_tag;

    logic [DATA_WIDTH-1:0]    best_value;
    logic [ADDRESS_WIDTH-1:0] best_addr;
    logic                     last_seen;
    logic [DATA_WIDTH-1:0]    key_cur, key_best;
    logic                     better;

`ifdef ARM_POSITION_SCANNER_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // Axis selects outside 0..NUM_AXES-1 compare the whole packed word.
    function automatic logic [DATA_WIDTH-1:0] key_of(input logic [DATA_WIDTH-1:0] data,
                                                     input logic [1:0]            sel);
        logic [DATA_WIDTH-1:0] k;
        k = data;
        for (int i = 0; i < NUM_AXES; i++) begin
            if (sel == 2'(i)) k = DATA_WIDTH'(data[i*AXIS_WIDTH +: AXIS_WIDTH]);
        end
        return k;
    endfunction

    // NOTE: the storage array has no reset branch; clearing it would turn the RAM into flops.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (state == SCAN) rd_data <= mem[rd_ptr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // NOTE: next_state gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE: if (start) next_state = SCAN;
            SCAN: begin
                if (abort_req)              next_state = IDLE;
                else if (remaining == '0)   next_state = FLUSH;
            end
            FLUSH: begin
                if (abort_req)              next_state = IDLE;
                else if (last_seen)         next_state = DONE;
            end
            default:                        next_state = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state == SCAN) || (state == FLUSH);
        accept = start && ((state == IDLE) || (state == DONE));
    end

    assign key_cur  = key_of(rd_data, sel_q);
    assign key_best = key_of(best_value, sel_q);
    assign better   = mode_q ? (key_cur < key_best) : (key_cur > key_best);

    // Two-stage pipeline: issue read, then compare; last_seen marks the final compare having landed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr        <= '0;
            remaining     <= '0;
            mode_q        <= 1'b0;
            sel_q         <= '0;
            first_pending <= 1'b0;
            rd_vld        <= 1'b0;
            rd_first      <= 1'b0;
            rd_last       <= 1'b0;
            rd_tag        <= '0;
            best_value    <= '0;
            best_addr     <= '0;
            last_seen     <= 1'b0;
            result_value  <= '0;
            result_addr   <= '0;
            valid         <= 1'b0;
            done          <= 1'b0;
        end else begin
            done      <= 1'b0;
            rd_vld    <= 1'b0;
            last_seen <= 1'b0;
            if (accept) begin
                rd_ptr        <= start_addr;
                remaining     <= end_addr - start_addr;
                mode_q        <= mode;
                sel_q         <= axis_sel;
                first_pending <= 1'b1;
                valid         <= 1'b0;
            end else if (abort_req && busy) begin
                valid <= 1'b0;
            end else begin
                if (state == SCAN) begin
                    rd_vld        <= 1'b1;
                    rd_tag        <= rd_ptr;
                    rd_first      <= first_pending;
                    rd_last       <= (remaining == '0);
                    first_pending <= 1'b0;
                    rd_ptr        <= rd_ptr + 1'b1;
                    remaining     <= remaining - 1'b1;
                end
                if (rd_vld) begin
                    if (rd_first || better) begin
                        best_value <= rd_data;
                        best_addr  <= rd_tag;
                    end
                    last_seen <= rd_last;
                end
                if ((state == FLUSH) && last_seen) begin
                    result_value <= best_value;
                    result_addr  <= best_addr;
                    valid        <= 1'b1;
                    done         <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_arm_position_scanner.sv
// Self-checking bench for arm_position_scanner: directed scenarios plus a table of scans
// whose expectations come from a shadow-memory model; results flow through a scoreboard queue.
module tb_arm_position_scanner;

    localparam int AW = 8;
    localparam int DW = 30;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] value;
        int            latency;
    } exp_t;

    typedef struct {
        logic [AW-1:0] sa;
        logic [AW-1:0] ea;
        logic          md;
        logic [1:0]    sel;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_value;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          start;
    logic [AW-1:0] start_addr, end_addr;
    logic          mode;
    logic [1:0]    axis_sel;
    logic          busy, done, valid;
    logic [DW-1:0] result_value;
    logic [AW-1:0] result_addr;
`ifdef ARM_POSITION_SCANNER_ABORT_EN
    logic          abort;
`endif

    logic [DW-1:0] model_mem [256];
    exp_t          sb [$];
    vec_t          vecs [9];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            cyc      = 0;

    arm_position_scanner dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .start        (start),
`ifdef ARM_POSITION_SCANNER_ABORT_EN
        .abort        (abort),
`endif
        .start_addr   (start_addr),
        .end_addr     (end_addr),
        .mode         (mode),
        .axis_sel     (axis_sel),
        .busy         (busy),
        .done         (done),
        .valid        (valid),
        .result_value (result_value),
        .result_addr  (result_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [DW-1:0] pack(input int x, input int y, input int z);
        return {10'(z), 10'(y), 10'(x)};
    endfunction

    function automatic logic [DW-1:0] key_of(input logic [DW-1:0] d, input logic [1:0] s);
        case (s)
            2'd0:    return DW'(d[9:0]);
            2'd1:    return DW'(d[19:10]);
            2'd2:    return DW'(d[29:20]);
            default: return d;
        endcase
    endfunction

    task automatic model_scan(input logic [AW-1:0] sa, input logic [AW-1:0] ea, input logic md,
                              input logic [1:0] sel, output logic [AW-1:0] ba,
                              output logic [DW-1:0] bv);
        logic [AW-1:0] n, a;
        logic [DW-1:0] k, bk;
        n  = ea - sa;
        ba = sa;
        bv = model_mem[sa];
        for (int i = 1; i <= int'(n); i++) begin
            a  = sa + AW'(i);
            k  = key_of(model_mem[a], sel);
            bk = key_of(bv, sel);
            if (md ? (k < bk) : (k > bk)) begin
                ba = a;
                bv = model_mem[a];
            end
        end
    endtask

    task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_en        = 1'b1;
        wr_addr      = a;
        wr_data      = d;
        model_mem[a] = d;
        step();
        wr_en        = 1'b0;
    endtask

    task automatic sync_mem();
        for (int i = 0; i < 256; i++) write_word(AW'(i), model_mem[i]);
    endtask

    task automatic launch(input logic [AW-1:0] sa, input logic [AW-1:0] ea, input logic md,
                          input logic [1:0] sel, input logic [AW-1:0] xa, input logic [DW-1:0] xv);
        exp_t          e;
        logic [AW-1:0] d;
        d         = ea - sa;
        e.addr    = xa;
        e.value   = xv;
        e.latency = int'(d) + 3;
        sb.push_back(e);
        start_addr = sa;
        end_addr   = ea;
        mode       = md;
        axis_sel   = sel;
        start      = 1'b1;
        step();
        start      = 1'b0;
        cyc        = 0;
        start_addr = ~sa;
        end_addr   = ~ea;
        mode       = ~md;
        axis_sel   = ~sel;
        check("busy_after_start", 64'(busy), 1);
        check("valid_cleared_on_start", 64'(valid), 0);
    endtask

    task automatic wait_done(input string name);
        exp_t e;
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            step();
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check({name, "_done_seen"}, 64'(seen), 1);
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_scoreboard: got empty queue, expected one pending result", name);
        end else begin
            e = sb.pop_front();
            if (seen) begin
                check({name, "_latency"}, 64'(cyc), 64'(e.latency));
                check({name, "_addr"}, 64'(result_addr), 64'(e.addr));
                check({name, "_value"}, 64'(result_value), 64'(e.value));
                check({name, "_valid"}, 64'(valid), 1);
                check({name, "_busy_low"}, 64'(busy), 0);
                step();
                check({name, "_done_one_cycle"}, 64'(done), 0);
                check({name, "_valid_held"}, 64'(valid), 1);
                check({name, "_addr_held"}, 64'(result_addr), 64'(e.addr));
            end
        end
    endtask

    initial begin
        logic [AW-1:0] xa;
        logic [DW-1:0] xv;
        int            cnt;

        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0;
        start_addr = '0; end_addr = '0; mode = 1'b0; axis_sel = '0;
`ifdef ARM_POSITION_SCANNER_ABORT_EN
        abort = 1'b0;
`endif
        #12;
        check("rst_busy", 64'(busy), 0);
        check("rst_done", 64'(done), 0);
        check("rst_valid", 64'(valid), 0);
        check("rst_result_value", 64'(result_value), 0);
        check("rst_result_addr", 64'(result_addr), 0);
        rst = 1'b0;
        step();

        // Ascending ramp, full-range maximum on the whole word.
        for (int i = 0; i < 256; i++) model_mem[i] = DW'(i);
        sync_mem();
        launch(8'd0, 8'd255, 1'b0, 2'd3, 8'd255, 30'd255);
        wait_done("full_ramp");

        // Tie on the minimum X keeps the first-scanned address.
        for (int i = 0; i < 256; i++) model_mem[i] = pack(9, i, 0);
        model_mem[10] = pack(5, 10, 0);
        model_mem[11] = pack(5, 11, 0);
        sync_mem();
        launch(8'd10, 8'd20, 1'b1, 2'd0, 8'd10, pack(5, 10, 0));
        wait_done("tie_min_x");
        check("tie_min_x_field", 64'(result_value[9:0]), 5);

        // Wrapping range 250..4; larger Z values sit just outside the range.
        for (int i = 0; i < 256; i++) model_mem[i] = pack(i, 3, 7);
        model_mem[2]   = pack(2, 3, 300);
        model_mem[5]   = pack(5, 3, 950);
        model_mem[249] = pack(249, 3, 950);
        model_mem[100] = pack(100, 3, 900);
        sync_mem();
        launch(8'd250, 8'd4, 1'b0, 2'd2, 8'd2, pack(2, 3, 300));
        wait_done("wrap_max_z");

        // Table of scans over random contents; expectations from the shadow model.
        for (int i = 0; i < 256; i++) model_mem[i] = DW'($urandom);
        model_mem[125][9:0] = 10'd0;
        model_mem[131][9:0] = 10'd0;
        sync_mem();
        vecs[0] = '{8'd0,   8'd255, 1'b0, 2'd3, '0, '0};
        vecs[1] = '{8'd0,   8'd255, 1'b1, 2'd3, '0, '0};
        vecs[2] = '{8'd17,  8'd17,  1'b0, 2'd0, '0, '0};
        vecs[3] = '{8'd200, 8'd40,  1'b1, 2'd1, '0, '0};
        vecs[4] = '{8'd255, 8'd0,   1'b0, 2'd2, '0, '0};
        vecs[5] = '{8'd30,  8'd90,  1'b1, 2'd2, '0, '0};
        vecs[6] = '{8'd5,   8'd4,   1'b1, 2'd0, '0, '0};
        vecs[7] = '{8'd64,  8'd127, 1'b0, 2'd1, '0, '0};
        vecs[8] = '{8'd120, 8'd135, 1'b1, 2'd0, '0, '0};
        for (int i = 0; i < 9; i++) begin
            model_scan(vecs[i].sa, vecs[i].ea, vecs[i].md, vecs[i].sel, xa, xv);
            vecs[i].exp_addr  = xa;
            vecs[i].exp_value = xv;
        end
        for (int i = 0; i < 9; i++) begin
            launch(vecs[i].sa, vecs[i].ea, vecs[i].md, vecs[i].sel,
                   vecs[i].exp_addr, vecs[i].exp_value);
            wait_done($sformatf("table%0d", i));
        end

        // A second start while busy must be ignored.
        model_scan(8'd0, 8'd99, 1'b0, 2'd3, xa, xv);
        launch(8'd0, 8'd99, 1'b0, 2'd3, xa, xv);
        repeat (4) step();
        start = 1'b1; start_addr = 8'd200; end_addr = 8'd210; mode = 1'b1; axis_sel = 2'd0;
        step();
        start = 1'b0;
        check("restart_ignored_busy", 64'(busy), 1);
        wait_done("restart_ignored");

        // Write to an unread address mid-scan is observed.
        model_mem[90] = 30'h3FFFFFFF;
        launch(8'd0, 8'd99, 1'b0, 2'd3, 8'd90, 30'h3FFFFFFF);
        repeat (9) step();
        wr_en = 1'b1; wr_addr = 8'd90; wr_data = 30'h3FFFFFFF;
        step();
        wr_en = 1'b0;
        wait_done("write_during_scan");

        // Write landing on the same edge as the read of that address returns the old word.
        write_word(8'd5, 30'd0);
        model_scan(8'd0, 8'd9, 1'b0, 2'd3, xa, xv);
        launch(8'd0, 8'd9, 1'b0, 2'd3, xa, xv);
        repeat (5) step();
        wr_en = 1'b1; wr_addr = 8'd5; wr_data = 30'h3FFFFFFF;
        step();
        wr_en = 1'b0;
        model_mem[5] = 30'h3FFFFFFF;
        wait_done("same_edge_old_data");
        launch(8'd0, 8'd9, 1'b0, 2'd3, 8'd5, 30'h3FFFFFFF);
        wait_done("same_edge_write_landed");

        // Reset in the middle of a scan clears outputs at once and nothing resumes.
        launch(8'd0, 8'd200, 1'b0, 2'd3, 8'd0, '0);
        repeat (10) step();
        rst = 1'b1;
        #1;
        check("midrst_busy", 64'(busy), 0);
        check("midrst_valid", 64'(valid), 0);
        check("midrst_done", 64'(done), 0);
        check("midrst_result_value", 64'(result_value), 0);
        check("midrst_result_addr", 64'(result_addr), 0);
        sb.delete();
        #2 rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (busy || done) cnt++;
        end
        check("no_resume_after_rst", 64'(cnt), 0);
        model_scan(8'd0, 8'd255, 1'b0, 2'd3, xa, xv);
        launch(8'd0, 8'd255, 1'b0, 2'd3, xa, xv);
        wait_done("after_rst_scan");

`ifdef ARM_POSITION_SCANNER_ABORT_EN
        // Abort during SCAN returns to IDLE without a done pulse.
        launch(8'd0, 8'd99, 1'b0, 2'd3, 8'd0, '0);
        repeat (4) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_busy", 64'(busy), 0);
        check("abort_valid", 64'(valid), 0);
        check("abort_done", 64'(done), 0);
        sb.delete();
        cnt = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (done || busy) cnt++;
        end
        check("abort_no_done", 64'(cnt), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
